// File: rtl/idu_if.sv
// Fetch->decode->execute handshake bundle for the instruction decode unit.
// The slave modport is the decode unit; the master modport is its environment
// (fetch stage driving words in, execute stage consuming bundles).
interface idu_if;
  logic        ifu_valid;
  logic [63:0] ifu_data;
  logic        idu_ready;
  logic        flush;
  logic        idu_valid;
  logic        exu_ready;
  logic [31:0] idu_pc;
  logic [31:0] idu_inst;
  logic [4:0]  idu_rd;
  logic [4:0]  idu_rs1;
  logic [4:0]  idu_rs2;
  logic [31:0] idu_imm;
  logic [3:0]  idu_opclass;
  logic [2:0]  idu_funct3;
  logic        idu_funct7b5;
  logic        idu_rf_wen;
  logic        idu_mem_ren;
  logic        idu_mem_wen;
  logic        idu_ebreak;
  logic        idu_illegal;
  logic [31:0] dec_count;

  modport slave (
    input  ifu_valid, ifu_data, flush, exu_ready,
    output idu_ready, idu_valid, idu_pc, idu_inst, idu_rd, idu_rs1, idu_rs2,
           idu_imm, idu_opclass, idu_funct3, idu_funct7b5, idu_rf_wen,
           idu_mem_ren, idu_mem_wen, idu_ebreak, idu_illegal, dec_count
  );

  modport master (
    output ifu_valid, ifu_data, flush, exu_ready,
    input  idu_ready, idu_valid, idu_pc, idu_inst, idu_rd, idu_rs1, idu_rs2,
           idu_imm, idu_opclass, idu_funct3, idu_funct7b5, idu_rf_wen,
           idu_mem_ren, idu_mem_wen, idu_ebreak, idu_illegal, dec_count
  );
endinterface

// File: rtl/idu.sv
// RV32I instruction decode unit: decodes fetched {inst, pc} words into a
// single registered bundle toward execute, with back-pressure, flush and a
// count of bundles retired into execute.
module idu #(
  parameter int WIDTH = 32
) (
  input logic  clk,
  input logic  rst_n,
  idu_if.slave bus
);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    F_I = 3'd0,
    F_S = 3'd1,
    F_B = 3'd2,
    F_U = 3'd3,
    F_J = 3'd4,
    F_R = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [3:0]  opclass;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        rf_wen;
    logic        mem_ren;
    logic        mem_wen;
    logic        ebreak;
    logic        illegal;
  } bundle_t;

  state_e      state_q, state_d;
  bundle_t     bundle_q, bundle_d;
  logic [31:0] dec_count_q, dec_count_d;

  logic [WIDTH-1:0] inst_s;
  logic [WIDTH-1:0] pc_s;
  logic             valid_s;
  logic             ready_s;
  logic             accept_s;
  logic             retire_s;
  bundle_t          dec_s;
  imm_fmt_e         fmt_s;
  logic             wen_class_s;

  assign inst_s   = bus.ifu_data[2*WIDTH-1:WIDTH];
  assign pc_s     = bus.ifu_data[WIDTH-1:0];
  assign valid_s  = (state_q == S_FULL);
  // Ready never looks at ifu_valid/ifu_data, so fetch can't form a loop through us.
  assign ready_s  = ~valid_s | bus.exu_ready | bus.flush;
  assign accept_s = bus.ifu_valid & ready_s & ~bus.flush;
  assign retire_s = valid_s & bus.exu_ready & ~bus.flush;

  // Decode the incoming fetch word into class, immediate format and flags.
  always_comb begin
    dec_s          = '0;
    fmt_s          = F_R;
    wen_class_s    = 1'b0;
    dec_s.pc       = pc_s;
    dec_s.inst     = inst_s;
    dec_s.rs1      = inst_s[19:15];
    dec_s.rs2      = inst_s[24:20];
    dec_s.funct3   = inst_s[14:12];
    dec_s.funct7b5 = inst_s[30];
    case (inst_s[6:0])
      7'b0110111: begin dec_s.opclass = 4'd0; fmt_s = F_U; wen_class_s = 1'b1; end
      7'b0010111: begin dec_s.opclass = 4'd1; fmt_s = F_U; wen_class_s = 1'b1; end
      7'b1101111: begin dec_s.opclass = 4'd2; fmt_s = F_J; wen_class_s = 1'b1; end
      7'b1100111: begin dec_s.opclass = 4'd3; fmt_s = F_I; wen_class_s = 1'b1; end
      7'b1100011: begin dec_s.opclass = 4'd4; fmt_s = F_B; end
      7'b0000011: begin dec_s.opclass = 4'd5; fmt_s = F_I; wen_class_s = 1'b1; dec_s.mem_ren = 1'b1; end
      7'b0100011: begin dec_s.opclass = 4'd6; fmt_s = F_S; dec_s.mem_wen = 1'b1; end
      7'b0010011: begin dec_s.opclass = 4'd7; fmt_s = F_I; wen_class_s = 1'b1; end
      7'b0110011: begin dec_s.opclass = 4'd8; fmt_s = F_R; wen_class_s = 1'b1; end
      7'b1110011: begin dec_s.opclass = 4'd9; fmt_s = F_I; end
      // Anything else, including a compressed-looking low pair, is illegal.
      default:    begin dec_s.opclass = 4'd15; fmt_s = F_R; dec_s.illegal = 1'b1; end
    endcase

    case (fmt_s)
      F_I:     dec_s.imm = {{20{inst_s[31]}}, inst_s[31:20]};
      F_S:     dec_s.imm = {{20{inst_s[31]}}, inst_s[31:25], inst_s[11:7]};
      F_B:     dec_s.imm = {{19{inst_s[31]}}, inst_s[31], inst_s[7], inst_s[30:25], inst_s[11:8], 1'b0};
      F_U:     dec_s.imm = {inst_s[31:12], 12'h000};
      F_J:     dec_s.imm = {{11{inst_s[31]}}, inst_s[31], inst_s[19:12], inst_s[20], inst_s[30:21], 1'b0};
      default: dec_s.imm = 32'h0000_0000;
    endcase

    // Writes to x0 are dropped, and rd reads as 0 whenever nothing is written.
    dec_s.rf_wen = wen_class_s & (inst_s[11:7] != 5'd0);
    if (dec_s.rf_wen) begin
      dec_s.rd = inst_s[11:7];
    end else begin
      dec_s.rd = 5'd0;
    end
    dec_s.ebreak = (inst_s == 32'h0010_0073);
  end

  // Next state, output register load and retire counter.
  always_comb begin
    state_d     = state_q;
    bundle_d    = bundle_q;
    dec_count_d = dec_count_q;
    case (state_q)
      S_EMPTY: begin
        if (accept_s) begin
          state_d = S_FULL;
        end else begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (bus.flush) begin
          state_d = S_EMPTY;
        end else if (accept_s) begin
          state_d = S_FULL;
        end else if (bus.exu_ready) begin
          state_d = S_EMPTY;
        end else begin
          state_d = S_FULL;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (accept_s) begin
      bundle_d = dec_s;
    end else begin
      bundle_d = bundle_q;
    end
    if (retire_s) begin
      dec_count_d = dec_count_q + 32'd1;
    end else begin
      dec_count_d = dec_count_q;
    end
  end

  // State, bundle and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      bundle_q    <= '0;
      dec_count_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      bundle_q    <= bundle_d;
      dec_count_q <= dec_count_d;
    end
  end

  assign bus.idu_ready    = ready_s;
  assign bus.idu_valid    = valid_s;
  assign bus.idu_pc       = bundle_q.pc;
  assign bus.idu_inst     = bundle_q.inst;
  assign bus.idu_rd       = bundle_q.rd;
  assign bus.idu_rs1      = bundle_q.rs1;
  assign bus.idu_rs2      = bundle_q.rs2;
  assign bus.idu_imm      = bundle_q.imm;
  assign bus.idu_opclass  = bundle_q.opclass;
  assign bus.idu_funct3   = bundle_q.funct3;
  assign bus.idu_funct7b5 = bundle_q.funct7b5;
  assign bus.idu_rf_wen   = bundle_q.rf_wen;
  assign bus.idu_mem_ren  = bundle_q.mem_ren;
  assign bus.idu_mem_wen  = bundle_q.mem_wen;
  assign bus.idu_ebreak   = bundle_q.ebreak;
  assign bus.idu_illegal  = bundle_q.illegal;
  assign bus.dec_count    = dec_count_q;

endmodule

// File: tb/tb_idu.sv
// Self-checking bench for idu: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_idu;

  logic clk;
  logic rst_n;
  idu_if bus();

  idu #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: is a bundle held, which word it came from, retire count.
  bit          m_valid;
  logic [31:0] m_inst;
  logic [31:0] m_pc;
  logic [31:0] m_count;
  bit          consumed;

  typedef struct {
    logic [31:0] imm;
    logic [3:0]  cls;
    logic        rfw, mr, mw, eb, il;
    logic [4:0]  rd;
  } ref_t;

  function automatic ref_t ref_decode(logic [31:0] i);
    ref_t r;
    logic [31:0] sx;
    logic [6:0]  op;
    op = i[6:0];
    sx = {32{i[31]}};
    if      (op == 7'h37) r.cls = 4'd0;
    else if (op == 7'h17) r.cls = 4'd1;
    else if (op == 7'h6F) r.cls = 4'd2;
    else if (op == 7'h67) r.cls = 4'd3;
    else if (op == 7'h63) r.cls = 4'd4;
    else if (op == 7'h03) r.cls = 4'd5;
    else if (op == 7'h23) r.cls = 4'd6;
    else if (op == 7'h13) r.cls = 4'd7;
    else if (op == 7'h33) r.cls = 4'd8;
    else if (op == 7'h73) r.cls = 4'd9;
    else                  r.cls = 4'd15;
    if (r.cls == 4'd3 || r.cls == 4'd5 || r.cls == 4'd7 || r.cls == 4'd9)
      r.imm = (sx << 12) | 32'(i[31:20]);
    else if (r.cls == 4'd6)
      r.imm = (sx << 12) | (32'(i[31:25]) << 5) | 32'(i[11:7]);
    else if (r.cls == 4'd4)
      r.imm = (sx << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
    else if (r.cls == 4'd0 || r.cls == 4'd1)
      r.imm = i & 32'hFFFF_F000;
    else if (r.cls == 4'd2)
      r.imm = (sx << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
    else
      r.imm = 32'h0;
    r.rfw = (r.cls inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd7, 4'd8}) && (i[11:7] != 5'd0);
    r.rd  = r.rfw ? i[11:7] : 5'd0;
    r.mr  = (r.cls == 4'd5);
    r.mw  = (r.cls == 4'd6);
    r.eb  = (i == 32'h0010_0073);
    r.il  = (r.cls == 4'd15);
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model.
  task automatic compare_all();
    ref_t r;
    check("valid", 32'(bus.idu_valid), 32'(m_valid));
    check("count", bus.dec_count, m_count);
    if (m_valid) begin
      r = ref_decode(m_inst);
      check("pc",      bus.idu_pc, m_pc);
      check("inst",    bus.idu_inst, m_inst);
      check("rd",      32'(bus.idu_rd), 32'(r.rd));
      check("rs1",     32'(bus.idu_rs1), 32'(m_inst[19:15]));
      check("rs2",     32'(bus.idu_rs2), 32'(m_inst[24:20]));
      check("imm",     bus.idu_imm, r.imm);
      check("opclass", 32'(bus.idu_opclass), 32'(r.cls));
      check("funct3",  32'(bus.idu_funct3), 32'(m_inst[14:12]));
      check("f7b5",    32'(bus.idu_funct7b5), 32'(m_inst[30]));
      check("rf_wen",  32'(bus.idu_rf_wen), 32'(r.rfw));
      check("mem_ren", 32'(bus.idu_mem_ren), 32'(r.mr));
      check("mem_wen", 32'(bus.idu_mem_wen), 32'(r.mw));
      check("ebreak",  32'(bus.idu_ebreak), 32'(r.eb));
      check("illegal", 32'(bus.idu_illegal), 32'(r.il));
    end
  endtask

  // One clock: check ready, advance the model at the edge, then compare.
  task automatic tick();
    bit rdy;
    #1;
    rdy = !m_valid || bus.exu_ready || bus.flush;
    check("ready", 32'(bus.idu_ready), 32'(rdy));
    @(posedge clk);
    consumed = bus.ifu_valid && rdy;
    if (m_valid && bus.exu_ready && !bus.flush) m_count = m_count + 32'd1;
    if (bus.flush) m_valid = 1'b0;
    else if (bus.ifu_valid && rdy) begin
      m_valid = 1'b1;
      m_inst  = bus.ifu_data[63:32];
      m_pc    = bus.ifu_data[31:0];
    end else if (bus.exu_ready) m_valid = 1'b0;
    #1;
    compare_all();
  endtask

  function automatic logic [31:0] gen_inst();
    logic [31:0] rnd;
    logic [6:0]  ops [10];
    int sel;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
    rnd = $urandom;
    sel = $urandom_range(0, 15);
    if (sel == 0) return rnd;
    if (sel == 1) return 32'h0010_0073;
    return {rnd[31:7], ops[$urandom_range(0, 9)]};
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_inst  = 32'h0;
    m_pc    = 32'h0;
    m_count = 32'h0;
  endtask

  task automatic send(logic [31:0] inst, logic [31:0] pc);
    bus.ifu_valid = 1'b1;
    bus.ifu_data  = {inst, pc};
  endtask

  logic [31:0] cnt_before;

  initial begin
    rst_n = 1'b0;
    bus.ifu_valid = 1'b0;
    bus.ifu_data  = 64'h0;
    bus.flush     = 1'b0;
    bus.exu_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst_valid", 32'(bus.idu_valid), 32'h0);
    check("rst_ready", 32'(bus.idu_ready), 32'h1);
    check("rst_count", bus.dec_count, 32'h0);
    check("rst_pc",    bus.idu_pc, 32'h0);
    check("rst_imm",   bus.idu_imm, 32'h0);
    check("rst_opc",   32'(bus.idu_opclass), 32'h0);

    // addi x1,x0,5
    bus.exu_ready = 1'b1;
    send(32'h0050_0093, 32'h8000_0000);
    tick();
    bus.ifu_valid = 1'b0;
    check("addi_valid", 32'(bus.idu_valid), 32'h1);
    check("addi_rd",    32'(bus.idu_rd), 32'd1);
    check("addi_rs1",   32'(bus.idu_rs1), 32'd0);
    check("addi_imm",   bus.idu_imm, 32'd5);
    check("addi_opc",   32'(bus.idu_opclass), 32'd7);
    check("addi_wen",   32'(bus.idu_rf_wen), 32'd1);
    check("addi_pc",    bus.idu_pc, 32'h8000_0000);
    tick();
    check("addi_count", bus.dec_count, 32'd1);

    // sw then beq back-to-back
    send(32'h0020_A423, 32'h8000_0004);
    tick();
    check("sw_imm", bus.idu_imm, 32'd8);
    check("sw_mw",  32'(bus.idu_mem_wen), 32'd1);
    check("sw_rd",  32'(bus.idu_rd), 32'd0);
    send(32'hFE00_0EE3, 32'h8000_0008);
    tick();
    bus.ifu_valid = 1'b0;
    check("beq_valid", 32'(bus.idu_valid), 32'd1);
    check("beq_imm",   bus.idu_imm, 32'hFFFF_FFFC);
    check("beq_opc",   32'(bus.idu_opclass), 32'd4);
    check("beq_wen",   32'(bus.idu_rf_wen), 32'd0);
    tick();

    // lui held under back-pressure, second word waits
    send(32'h1234_52B7, 32'h8000_0010);
    tick();
    bus.exu_ready = 1'b0;
    send(32'h0050_0093, 32'h8000_0014);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("stall_ready", 32'(bus.idu_ready), 32'd0);
      check("stall_imm",   bus.idu_imm, 32'h1234_5000);
      check("stall_inst",  bus.idu_inst, 32'h1234_52B7);
    end
    bus.exu_ready = 1'b1;
    tick();
    bus.ifu_valid = 1'b0;
    check("unstall_inst", bus.idu_inst, 32'h0050_0093);

    // ebreak and all-zero illegal
    send(32'h0010_0073, 32'h8000_0020);
    tick();
    check("ebrk_eb",  32'(bus.idu_ebreak), 32'd1);
    check("ebrk_opc", 32'(bus.idu_opclass), 32'd9);
    send(32'h0000_0000, 32'h8000_0024);
    tick();
    bus.ifu_valid = 1'b0;
    check("ill_il",  32'(bus.idu_illegal), 32'd1);
    check("ill_opc", 32'(bus.idu_opclass), 32'd15);
    check("ill_en",  32'({bus.idu_rf_wen, bus.idu_mem_ren, bus.idu_mem_wen, bus.idu_ebreak}), 32'd0);

    // flush while full and stalled, with a word arriving
    bus.exu_ready = 1'b0;
    tick();
    cnt_before = m_count;
    send(32'h0000_0013, 32'h8000_0030);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    bus.ifu_valid = 1'b0;
    check("flush_valid", 32'(bus.idu_valid), 32'd0);
    check("flush_count", bus.dec_count, cnt_before);
    bus.exu_ready = 1'b1;
    tick();
    check("flush_gone", 32'(bus.idu_valid), 32'd0);

    // asynchronous reset mid-cycle while full
    bus.exu_ready = 1'b0;
    send(32'h0000_0013, 32'h8000_0040);
    tick();
    bus.ifu_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.idu_valid), 32'd0);
    check("arst_count", bus.dec_count, 32'd0);
    model_reset();
    rst_n = 1'b1;

    // randomized traffic
    consumed = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (!bus.ifu_valid || consumed) begin
        bus.ifu_valid = ($urandom_range(0, 3) != 0);
        bus.ifu_data  = {gen_inst(), 32'($urandom)};
      end
      bus.exu_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/idu.md
# idu

Instruction decode unit. Accepts fetched `{inst, pc}` words from the fetch stage over a valid/ready handshake, decodes RV32I base instructions into register indices, a sign-extended immediate and control flags, and holds the decoded bundle in one output register toward the execute stage over a second valid/ready handshake. It is the consumer end of the fetch→decode interface. It provides full-throughput pass-through, back-pressure, flush and a retired-decode counter.

## Interface
Parameters:
- `WIDTH`, 32, instruction and pc width; only 32 is supported.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `ifu_valid`  in  1  fetch word present.
- `ifu_data`  in  64  `[63:32]` = inst, `[31:0]` = pc; stable while `ifu_valid` is high and not accepted.
- `idu_ready`  out  1  decode can accept this cycle.
- `flush`  in  1  kill held and incoming instruction (redirect).
- `idu_valid`  out  1  decoded bundle valid.
- `exu_ready`  in  1  execute accepts bundle.
- `idu_pc`, `idu_inst`  out  32 each  registered pc and raw instruction.
- `idu_rd`, `idu_rs1`, `idu_rs2`  out  5 each  register indices.
- `idu_imm`  out  32  sign-extended immediate.
- `idu_opclass`  out  4  0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OP-IMM, 8 OP, 9 SYSTEM, 15 illegal.
- `idu_funct3`  out  3;  `idu_funct7b5`  out  1  (inst[30]).
- `idu_rf_wen`, `idu_mem_ren`, `idu_mem_wen`, `idu_ebreak`, `idu_illegal`  out  1 each.
- `dec_count`  out  32  number of bundles accepted by execute.

## Operation
- Two states: `S_EMPTY` (output register free) and `S_FULL` (bundle held, `idu_valid`=1).
- `idu_ready = !idu_valid | exu_ready | flush`.
- Accept (`ifu_valid & idu_ready & !flush`): decode combinationally from `ifu_data`, load output register, go/stay `S_FULL`.
- `S_FULL` & `exu_ready` & no accept → `S_EMPTY`. `S_FULL` & `exu_ready` & accept → stays `S_FULL` with new bundle (back-to-back, 1 instruction/cycle).
- `S_FULL` & `!exu_ready` → bundle frozen; all outputs bit-stable.
- `flush`=1: next state `S_EMPTY` regardless of other inputs; incoming word is consumed (ready high) and dropped; held bundle is discarded, not counted.
- Immediate by format: I `{{20{i[31]}},i[31:20]}`; S `{{20{i[31]}},i[31:25],i[11:7]}`; B `{{19{i[31]}},i[31],i[7],i[30:25],i[11:8],1'b0}`; U `{i[31:12],12'b0}`; J `{{11{i[31]}},i[31],i[19:12],i[20],i[30:21],1'b0}`; R-type and illegal → 0.
- `rf_wen`=1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP; forced 0 when rd=0. `idu_rd` forced 0 when `rf_wen`=0.
- `mem_ren` LOAD only; `mem_wen` STORE only. `ebreak` iff inst == 0x00100073.
- Illegal: inst[1:0]≠2'b11 or opcode not in the 10 classes above → opclass 15, all enables 0, `illegal`=1; bundle still delivered.
- `dec_count` increments by 1 on `idu_valid & exu_ready & !flush`; wraps 0xFFFFFFFF→0.

## Timing
- Reset (async, `rst_n`=0): state `S_EMPTY`, `idu_valid`=0, all bundle outputs 0, `dec_count`=0; `idu_ready` then evaluates to 1. Deassertion takes effect at the next rising edge; reset mid-transfer discards the held bundle.
- Latency: word accepted at edge N → `idu_valid` and bundle visible after edge N, i.e. one cycle.
- `idu_ready` is combinational from `idu_valid`, `exu_ready`, `flush`; no combinational path from `ifu_valid` or `ifu_data` to `idu_ready`.
- Throughput 1 per cycle with `exu_ready` held high; no bubble on back-to-back transfers.
- `idu_valid` never drops without `exu_ready` or `flush`.

## Test plan
- Reset then `ifu_data={0x00500093,0x80000000}` (addi x1,x0,5) one cycle, `exu_ready`=1 → next cycle `idu_valid`=1, rd=1, rs1=0, imm=5, opclass=7, rf_wen=1, pc=0x80000000; `dec_count`=1 one cycle later.
- inst 0x0020A423 (sw x2,8(x1)) then 0xFE000EE3 (beq x0,x0,-4) back-to-back → imm 8, mem_wen=1, rd=0; then imm 0xFFFFFFFC, opclass 4, rf_wen=0; no bubble.
- inst 0x123452B7 (lui x5,0x12345) with `exu_ready`=0 for 3 cycles → `idu_ready`=0, bundle stable (imm 0x12345000), second pending fetch word not accepted until `exu_ready`=1.
- inst 0x00100073 → ebreak=1, opclass 9; inst 0x00000000 → illegal=1, opclass 15, all enables 0.
- `S_FULL` with `exu_ready`=0, assert `flush` with `ifu_valid`=1 → next cycle `idu_valid`=0, `dec_count` unchanged, flushed words never appear.
- Assert `rst_n`=0 asynchronously mid-cycle while `S_FULL` → `idu_valid` and `dec_count` go 0 immediately, before the next edge.
